// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the daisy-chained configuration shift segment.
package cfg_chain_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, COMMIT, DONE} state_e;

  // Bit of the trailing beat that carries the expected even parity.
  localparam int PAR_BIT = 0;

  function automatic int beats(input int cfg_bits, input int ser_w);
    return cfg_bits / ser_w;
  endfunction
endpackage

// File: rtl/cfg_shift_core.sv
// Data path of one segment: shift register, beat counter and running parity.
module cfg_shift_core
  import cfg_chain_pkg::*;
#(
  parameter int CFG_BITS = 96,
  parameter int SER_W    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                shift_en,
  input  logic [SER_W-1:0]    bit_in,
  output logic [CFG_BITS-1:0] sr,
  output logic                par_acc,
  output logic                done
);
  localparam int BEATS = beats(CFG_BITS, SER_W);
  localparam int CW    = $clog2(BEATS + 1);

  logic [CW-1:0] cnt;

  // sr is not cleared at session start: a new load overwrites every bit anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      cnt     <= '0;
      par_acc <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      par_acc <= 1'b0;
    end else if (shift_en) begin
      sr      <= {sr[CFG_BITS-SER_W-1:0], bit_in};
      cnt     <= cnt + 1'b1;
      par_acc <= par_acc ^ (^bit_in);
    end
  end

  assign done = shift_en && (cnt == CW'(BEATS - 1));
endmodule

// File: rtl/cfg_chain_seg.sv
// Configuration-shift segment: token-chained loader with parity check and shadow commit.
module cfg_chain_seg
  import cfg_chain_pkg::*;
#(
  parameter int CFG_BITS = 96,
  parameter int SER_W    = 1,
  parameter bit SHADOW   = 1'b1,
  parameter bit CHK_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prgm_b,
  input  logic                seg_en,
  input  logic                chain_in,
  input  logic [SER_W-1:0]    bit_in,
  input  logic                bit_valid,
  output logic                chain_out,
  output logic [SER_W-1:0]    bit_out,
  output logic                bit_out_valid,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_valid,
  output logic                par_err
);
  if (CFG_BITS % SER_W != 0) begin : g_bad_width
    $error("cfg_chain_seg: CFG_BITS must be a multiple of SER_W");
  end

  state_e              state, nxt;
  logic                act, acc, clr, data_acc, commit, par_fail, done, par_acc;
  logic [CFG_BITS-1:0] sr;

  assign act = !prgm_b && seg_en && chain_in;
  assign acc = act && bit_valid;

  cfg_shift_core #(.CFG_BITS(CFG_BITS), .SER_W(SER_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .shift_en (data_acc),
    .bit_in   (bit_in),
    .sr       (sr),
    .par_acc  (par_acc),
    .done     (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Deasserting prgm_b aborts from any state; other inputs only pause.
  always_comb begin
    nxt      = state;
    clr      = 1'b0;
    data_acc = 1'b0;
    commit   = 1'b0;
    par_fail = 1'b0;
    if (prgm_b) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (act) begin
          nxt = SHIFT;
          clr = 1'b1;
        end
        SHIFT: if (acc) begin
          data_acc = 1'b1;
          if (done) nxt = CHK_EN ? CHECK : COMMIT;
        end
        CHECK: if (acc) begin
          if (bit_in[PAR_BIT] == par_acc) nxt = COMMIT;
          else begin
            nxt      = DONE;
            par_fail = 1'b1;
          end
        end
        COMMIT: begin
          commit = 1'b1;
          nxt    = DONE;
        end
        default: nxt = state;
      endcase
    end
  end

  assign chain_out = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_valid     <= 1'b0;
      par_err       <= 1'b0;
      bit_out       <= '0;
      bit_out_valid <= 1'b0;
    end else begin
      if (clr)           par_err <= 1'b0;
      else if (par_fail) par_err <= 1'b1;
      if (commit)                cfg_valid <= 1'b1;
      else if (clr && !SHADOW)   cfg_valid <= 1'b0;
      if (state == DONE && !prgm_b) bit_out <= bit_in;
      bit_out_valid <= (state == DONE) && !prgm_b && bit_valid;
    end
  end

  if (SHADOW) begin : g_shadow
    logic [CFG_BITS-1:0] cfg_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       cfg_q <= '0;
      else if (commit) cfg_q <= sr;
    end
    assign cfg_out = cfg_q;
  end else begin : g_live
    assign cfg_out = sr;
  end
endmodule

// File: tb/tb_cfg_chain_seg.sv
// Randomized self-checking bench for cfg_chain_seg (1-bit and 4-bit serial instances).
module tb_cfg_chain_seg;
  logic        clk = 1'b0;
  logic        reset;
  // SER_W=1 instance
  logic        prgm_b, seg_en, chain_in, bit_valid;
  logic [0:0]  bit_in, bit_out;
  logic        chain_out, bit_out_valid, cfg_valid, par_err;
  logic [95:0] cfg_out;
  // SER_W=4 instance
  logic        prgm_b4, seg_en4, chain_in4, bit_valid4;
  logic [3:0]  bit_in4, bit_out4;
  logic        chain_out4, bit_out_valid4, cfg_valid4, par_err4;
  logic [95:0] cfg_out4;

  int          n_chk = 0, n_err = 0;
  logic [95:0] exp_cfg = '0;
  logic        exp_valid = 1'b0, exp_err = 1'b0;
  logic [95:0] d;

  always #5 clk = ~clk;

  cfg_chain_seg #(.CFG_BITS(96), .SER_W(1), .SHADOW(1'b1), .CHK_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .prgm_b(prgm_b), .seg_en(seg_en), .chain_in(chain_in),
    .bit_in(bit_in), .bit_valid(bit_valid), .chain_out(chain_out), .bit_out(bit_out),
    .bit_out_valid(bit_out_valid), .cfg_out(cfg_out), .cfg_valid(cfg_valid), .par_err(par_err)
  );

  cfg_chain_seg #(.CFG_BITS(96), .SER_W(4), .SHADOW(1'b1), .CHK_EN(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .prgm_b(prgm_b4), .seg_en(seg_en4), .chain_in(chain_in4),
    .bit_in(bit_in4), .bit_valid(bit_valid4), .chain_out(chain_out4), .bit_out(bit_out4),
    .bit_out_valid(bit_out_valid4), .cfg_out(cfg_out4), .cfg_valid(cfg_valid4), .par_err(par_err4)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Streams data d (first beat = MSB) then parity p into the SER_W=1 instance.
  // abort_kind: 0 complete, 1 prgm_b abort after abort_at beats, 2 reset after abort_at beats.
  task automatic session(input logic [95:0] dat, input logic p, input bit gaps,
                         input int pause_at, input int abort_at, input int abort_kind);
    int i, cyc, hold, nb;
    bit paused, v;
    prgm_b = 1'b1; bit_valid = 1'b0; chain_in = 1'b1; seg_en = 1'b1;
    @(negedge clk);
    chk("idle_chain_out", chain_out, 0);
    prgm_b = 1'b0;
    @(negedge clk);
    exp_err = 1'b0;
    chk("start_par_err", par_err, 0);
    nb = (abort_kind != 0) ? abort_at : 97;
    i = 0; cyc = 0; hold = 0; paused = 1'b0;
    while (i < nb && cyc < 3000) begin
      v = gaps ? (cyc % 3 != 2) : 1'b1;
      if (i == pause_at && !paused) begin paused = 1'b1; hold = 5; end
      chain_in = (hold == 0);
      if (hold > 0) hold--;
      bit_valid = v;
      bit_in[0] = (i < 96) ? dat[95-i] : p;
      @(negedge clk);
      cyc++;
      if (v && chain_in) i++;
    end
    bit_valid = 1'b0; chain_in = 1'b1;
    if (cyc >= 3000) chk("stream_timeout", cyc, 0);
    if (abort_kind == 1) begin
      chk("mid_load_cfg", cfg_out, exp_cfg);
      prgm_b = 1'b1;
      @(negedge clk);
      chk("abort_chain_out", chain_out, 0);
      chk("abort_cfg_out", cfg_out, exp_cfg);
      chk("abort_cfg_valid", cfg_valid, exp_valid);
      chk("abort_par_err", par_err, exp_err);
      return;
    end
    if (abort_kind == 2) begin
      #2 reset = 1'b1;
      #1;
      exp_cfg = '0; exp_valid = 1'b0; exp_err = 1'b0;
      chk("rst_cfg_out", cfg_out, 0);
      chk("rst_cfg_valid", cfg_valid, 0);
      chk("rst_par_err", par_err, 0);
      chk("rst_chain_out", chain_out, 0);
      chk("rst_bit_out", bit_out, 0);
      chk("rst_bit_out_valid", bit_out_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    // One clock after the parity beat a good load sits in its commit cycle.
    if (p == ^dat) begin
      chk("commit_chain_out", chain_out, 0);
      chk("commit_cfg_old", cfg_out, exp_cfg);
    end
    @(negedge clk);
    if (p == ^dat) begin
      exp_cfg = dat; exp_valid = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    chk("done_chain_out", chain_out, 1);
    chk("done_cfg_out", cfg_out, exp_cfg);
    chk("done_cfg_valid", cfg_valid, exp_valid);
    chk("done_par_err", par_err, exp_err);
  endtask

  // Pass-through after done; seg_en and chain_in dropped to show it is ungated.
  task automatic echo1(input int n);
    logic pb, pv;
    seg_en = 1'b0; chain_in = 1'b0;
    for (int k = 0; k < n; k++) begin
      pb = 1'($urandom); pv = 1'($urandom);
      bit_in[0] = pb; bit_valid = pv;
      @(negedge clk);
      chk("echo_valid", bit_out_valid, pv);
      chk("echo_data", bit_out, pb);
      chk("echo_chain_hold", chain_out, 1);
    end
    bit_valid = 1'b0; seg_en = 1'b1; chain_in = 1'b1;
  endtask

  task automatic session4(input logic [95:0] dat, input logic p);
    logic [3:0] pb;
    logic       pv;
    prgm_b4 = 1'b1; bit_valid4 = 1'b0;
    @(negedge clk);
    prgm_b4 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      bit_in4 = dat[95-4*k -: 4]; bit_valid4 = 1'b1;
      @(negedge clk);
    end
    bit_in4 = {3'b000, p};
    @(negedge clk);
    bit_valid4 = 1'b0;
    chk("w4_commit_chain_out", chain_out4, (p == ^dat) ? 96'd0 : 96'd1);
    @(negedge clk);
    chk("w4_chain_out", chain_out4, 1);
    chk("w4_par_err", par_err4, (p == ^dat) ? 96'd0 : 96'd1);
    if (p == ^dat) begin
      chk("w4_cfg_out", cfg_out4, dat);
      chk("w4_cfg_valid", cfg_valid4, 1);
    end
    for (int k = 0; k < 6; k++) begin
      pb = 4'($urandom); pv = 1'($urandom);
      bit_in4 = pb; bit_valid4 = pv;
      @(negedge clk);
      chk("w4_echo_valid", bit_out_valid4, pv);
      chk("w4_echo_data", bit_out4, pb);
    end
    bit_valid4 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    prgm_b = 1'b1; seg_en = 1'b1; chain_in = 1'b1; bit_valid = 1'b0; bit_in = '0;
    prgm_b4 = 1'b1; seg_en4 = 1'b1; chain_in4 = 1'b1; bit_valid4 = 1'b0; bit_in4 = '0;
    repeat (2) @(negedge clk);
    chk("reset_cfg_out", cfg_out, 0);
    chk("reset_cfg_valid", cfg_valid, 0);
    chk("reset_par_err", par_err, 0);
    chk("reset_chain_out", chain_out, 0);
    chk("reset_bit_out_valid", bit_out_valid, 0);
    reset = 1'b0;
    @(negedge clk);

    // Commit something, then reset mid-load after 30 beats and reload from scratch.
    d = {$urandom, $urandom, $urandom};
    session(d, ^d, 1'b0, -1, 0, 0);
    d = {$urandom, $urandom, $urandom};
    session(d, ^d, 1'b0, -1, 30, 2);
    d = {$urandom, $urandom, $urandom};
    session(d, ^d, 1'b0, -1, 0, 0);

    d = {12{8'hA5}};
    session(d, 1'b0, 1'b0, -1, 0, 0);
    echo1(8);

    // Bad parity must leave the previously committed word in place.
    d = {$urandom, $urandom, $urandom};
    session(d, ^d, 1'b0, -1, 0, 0);
    d = {12{8'hA5}};
    session(d, 1'b1, 1'b0, -1, 0, 0);

    d = {12{8'hA5}};
    session(d, 1'b0, 1'b1, 50, 0, 0);

    d = {$urandom, $urandom, $urandom};
    session(d, ^d, 1'b0, -1, 40, 1);
    d = {$urandom, $urandom, $urandom};
    session(d, ^d, 1'b0, -1, 0, 0);

    for (int r = 0; r < 4; r++) begin
      d = {$urandom, $urandom, $urandom};
      session(d, (^d) ^ ($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 96), 0, 0);
    end

    d = {24{4'h3}};
    session4(d, 1'b0);
    d = {$urandom, $urandom, $urandom};
    session4(d, ^d);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
